// File: rtl/dsp_mac_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dsp_mac_sequencer_pkg                                              |
// | Shared DSP slice opcodes, slice widths and sequencer state codes.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dsp_mac_sequencer_pkg;

   localparam int c_A_W = 18;
   localparam int c_P_W = 48;

   localparam logic [1:0] c_OP_CLR = 2'b00;
   localparam logic [1:0] c_OP_MAC = 2'b01;
   localparam logic [1:0] c_OP_ACC = 2'b10;
   localparam logic [1:0] c_OP_NOP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_BIAS   = 3'd2,
      ST_MAC    = 3'd3,
      ST_RESULT = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dsp_mac_sequencer                                                  |
// | Job controller driving one MAC slice: CLR, optional bias, MACs.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dsp_mac_sequencer
   import dsp_mac_sequencer_pkg::*;
#(
   parameter int LEN_W = 16,
   parameter int A_W   = c_A_W,
   parameter int P_W   = c_P_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             bias_en,
   input  logic [P_W-1:0]   bias,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [A_W-1:0]   op_a,
   input  logic [A_W-1:0]   op_b,
   output logic [1:0]       dsp_op,
   output logic [A_W-1:0]   dsp_a,
   output logic [A_W-1:0]   dsp_b,
   output logic [P_W-1:0]   dsp_c,
   input  logic [P_W-1:0]   dsp_p,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [P_W-1:0]   res_data
);

   state_t           r_state;
   logic [LEN_W-1:0] r_remaining;
   logic [P_W-1:0]   r_bias;
   logic             r_bias_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_bias      <= '0;
         r_bias_en   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_remaining <= len;
                  r_bias      <= bias;
                  r_bias_en   <= bias_en;
                  r_state     <= ST_CLR;
               end
            end
            ST_CLR: begin
               if (r_bias_en)
                  r_state <= ST_BIAS;
               else if (r_remaining != '0)
                  r_state <= ST_MAC;
               else
                  r_state <= ST_RESULT;
            end
            ST_BIAS: begin
               r_state <= (r_remaining != '0) ? ST_MAC : ST_RESULT;
            end
            ST_MAC: begin
               // remaining is at least 1 whenever MAC is entered, so no underflow
               if (op_valid) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == LEN_W'(1))
                     r_state <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (res_ready)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state != ST_IDLE);
      op_ready  = (r_state == ST_MAC);
      res_valid = (r_state == ST_RESULT);
      res_data  = '0;
      dsp_op    = c_OP_NOP;
      dsp_a     = '0;
      dsp_b     = '0;
      dsp_c     = '0;
      case (r_state)
         ST_CLR:  dsp_op = c_OP_CLR;
         ST_BIAS: begin
            dsp_op = c_OP_ACC;
            dsp_c  = r_bias;
         end
         ST_MAC: begin
            if (op_valid) begin
               dsp_op = c_OP_MAC;
               dsp_a  = op_a;
               dsp_b  = op_b;
            end
         end
         // slice sees NOP here, so p is stable for the whole handshake
         ST_RESULT: res_data = dsp_p;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Job-level controller for one DSP48-style MAC slice (op/a/b/c in, 48-bit p out, one-cycle registered update). It accepts a job command (term count plus optional bias), clears the accumulator, optionally preloads the bias via ACC, and streams operand pairs into the slice as MAC ops. It then presents the final p on a valid/ready result port. It sits between the convolution window fetch logic and the DSP slice, and is the only block that drives the slice's opcode.

Parameters:
LEN_W, 16, width of the job term count; max terms per job = 2^LEN_W-1
A_W, 18, DSP multiplier operand width (fixed by the slice)
P_W, 48, DSP accumulator/result width (fixed by the slice)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; accepted only in IDLE
len  in  LEN_W  number of MAC terms for the job, sampled on accepted start
bias_en  in  1  preload bias before MACs, sampled on accepted start
bias  in  P_W  bias value, sampled on accepted start
busy  out  1  high in every state except IDLE
op_valid  in  1  operand pair available
op_ready  out  1  sequencer accepts operand pair this cycle
op_a  in  A_W  operand A
op_b  in  A_W  operand B
dsp_op  out  2  slice opcode: CLR=00, MAC=01, ACC=10, NOP=11
dsp_a  out  A_W  slice input A
dsp_b  out  A_W  slice input B
dsp_c  out  P_W  slice input C
dsp_p  in  P_W  slice output p
res_valid  out  1  final result available
res_ready  in  1  consumer takes result
res_data  out  P_W  final accumulated value

Behaviour:
- States: IDLE, CLR, BIAS, MAC, RESULT. Registers: state, remaining (LEN_W), bias_q (P_W), bias_en_q.
- Reset (async, rst_n=0): state=IDLE, remaining=0, bias_q=0. Outputs: busy=0, op_ready=0, res_valid=0, dsp_op=NOP, dsp_a=0, dsp_b=0, dsp_c=0.
- IDLE: dsp_op=NOP. If start=1, latch len/bias/bias_en and go to CLR at the next edge.
- CLR (1 cycle): dsp_op=CLR. Next state is BIAS if bias_en_q=1. Otherwise next state is MAC if remaining!=0, else RESULT.
- BIAS (1 cycle): dsp_op=ACC, dsp_c=bias_q. Next state is MAC if remaining!=0, else RESULT.
- MAC: op_ready=1.
  - If op_valid=1, the pair is accepted: dsp_op=MAC, dsp_a=op_a, dsp_b=op_b (combinational pass-through), remaining decrements. If remaining was 1, next state is RESULT.
  - If op_valid=0: dsp_op=NOP, stay in MAC. Stalls of any length are legal.
- RESULT: dsp_op=NOP, so p holds. res_valid=1, res_data=dsp_p. On res_valid&res_ready, go to IDLE.
- res_valid and res_data stay stable while res_ready=0.
- dsp_c=bias_q only in BIAS, otherwise 0. dsp_a/dsp_b=0 except on accepted MAC cycles.
- Latency: start accepted at cycle t gives CLR at t+1, optional BIAS at t+2, first MAC at the next cycle. Result is valid the cycle after the last accepted pair.
- len=0: no operands are accepted. Result = bias (bias_en=1) or 0.
- start while busy is ignored; no queueing.
- start in the same cycle as the RESULT handshake is ignored; it must be re-asserted in IDLE.
- Arithmetic (wrap, sign) belongs to the slice. The sequencer performs no arithmetic besides the remaining decrement, which never underflows.
- Reset mid-job: immediate return to IDLE with reset outputs. The stale slice p is harmless because every job begins with CLR.

Decomposition:
- Shared package: DSP opcode constants (CLR/MAC/ACC/NOP), A_W and P_W widths, and the state encoding.
- No sub-module. The DSP slice is instantiated alongside this block in the parent and in the bench, not inside this block.

Test Plan:
- len=3, bias_en=0, pairs (2,3),(4,5),(6,7) offered back-to-back: dsp_op sequence CLR,MAC,MAC,MAC,NOP; res_data=68, res_valid exactly one cycle after the third MAC.
- Same job with bias_en=1, bias=100: sequence CLR,ACC,MAC×3; res_data=168.
- Same pairs with op_valid low 2 cycles between each pair: NOPs during the gaps, op_ready high throughout MAC, res_data=68.
- len=0, bias_en=1, bias=5: no op_ready pulse; sequence CLR,ACC; res_data=5. len=0 with bias_en=0: res_data=0.
- res_ready held low 4 cycles in RESULT while start pulses: res_valid/res_data stable at the final value, start ignored, busy=1; IDLE follows the handshake.
- rst_n asserted mid-MAC after 2 of 5 pairs: outputs go to reset values asynchronously. A new job len=2 with (1,1),(3,3) then returns 10.
